// File: rtl/rv32i_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package rv32i_pkg;

    localparam int        ROM_DEPTH = 128;
    localparam int        ROM_W     = 32;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/im_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words and keeps a running XOR of every byte.
module im_word_assembler
    import rv32i_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [7:0]       byte_in,
    input  logic             stb,
    output logic [ROM_W-1:0] word,
    output logic             word_vld,
    output logic [7:0]       chk
);

    logic [1:0]  lane_p0;
    logic [23:0] lo_p0;
    logic [7:0]  chk_p0;

    // The fourth byte completes the word combinationally; the loader registers it.
    assign word     = {byte_in, lo_p0};
    assign word_vld = stb && (lane_p0 == 2'd3);
    assign chk      = chk_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_p0 <= 2'd0;
            chk_p0  <= 8'd0;
        end else if (clr) begin
            lane_p0 <= 2'd0;
            chk_p0  <= 8'd0;
        end else if (stb) begin
            lane_p0 <= lane_p0 + 2'd1;
            chk_p0  <= chk_p0 ^ byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (stb) begin
            case (lane_p0)
                2'd0:    lo_p0[7:0]   <= byte_in;
                2'd1:    lo_p0[15:8]  <= byte_in;
                2'd2:    lo_p0[23:16] <= byte_in;
                default: lo_p0        <= lo_p0;
            endcase
        end
    end

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction memory writer: parses SYNC/N/data/CHK frames and holds the CPU while loading.
module im_loader
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              clr,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [ROM_W-1:0]  im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    state_t           state, state_nxt;
    logic             acc;
    logic [7:0]       n_words;
    logic [7:0]       word_idx;
    logic [ROM_W-1:0] asm_word;
    logic             asm_vld;
    logic [7:0]       asm_chk;

    assign rx_ready = (state != DONE) && (state != ERR);
    assign acc      = rx_valid && rx_ready;
    assign cpu_hold = (state == COUNT) || (state == DATA) || (state == CHECK) || (state == ERR);
    assign done     = (state == DONE);
    assign err      = (state == ERR);

    im_word_assembler u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == COUNT),
        .byte_in  (rx_data),
        .stb      (acc && (state == DATA)),
        .word     (asm_word),
        .word_vld (asm_vld),
        .chk      (asm_chk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (acc && (rx_data == SYNC_BYTE)) state_nxt = COUNT;
            COUNT: if (acc) begin
                       if ((rx_data == 8'd0) || (rx_data > 8'(ROM_DEPTH))) state_nxt = ERR;
                       else                                                  state_nxt = DATA;
                   end
            DATA:  if (asm_vld && (word_idx == n_words - 8'd1)) state_nxt = CHECK;
            CHECK: if (acc) state_nxt = (rx_data == asm_chk) ? DONE : ERR;
            DONE:  if (clr) state_nxt = IDLE;
            ERR:   if (clr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write port stage: one strobe per completed word; address and data hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_words  <= 8'd0;
            word_idx <= 8'd0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
        end else begin
            im_we <= asm_vld;
            if ((state == COUNT) && acc) begin
                n_words  <= rx_data;
                word_idx <= 8'd0;
            end
            if (asm_vld) begin
                im_addr  <= ADDR_W'({word_idx, 2'b00});
                im_wdata <= asm_word;
                word_idx <= word_idx + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: a cycle-accurate vector table plus multi-cycle frame scenarios.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        clr = 1'b0;
    logic        im_we;
    logic [15:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold, done, err;

    int checks = 0;
    int failures = 0;

    im_loader #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .clr(clr), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic        c;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wd;
        logic        hold, dn, er, rdy;
    } vec_t;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t wq[$];

    always @(negedge clk) if (rst_n && im_we) wq.push_back({im_addr, im_wdata});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] d, input logic v, input logic c);
        @(negedge clk);
        rx_data = d; rx_valid = v; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(b, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cyc(8'h00, 1'b0, 1'b0);
    endtask

    task automatic pulse_clr();
        cyc(8'h00, 1'b0, 1'b1);
        idle();
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic c,
                                input logic we, input logic [15:0] a, input logic [31:0] wd,
                                input logic h, input logic dn, input logic er, input logic r);
        vec_t t;
        t.d = d; t.v = v; t.c = c; t.we = we; t.addr = a; t.wd = wd;
        t.hold = h; t.dn = dn; t.er = er; t.rdy = r;
        return t;
    endfunction

    task automatic send_good(input bit gaps);
        logic [7:0] fr[11];
        fr = '{8'hA5, 8'h02, 8'h93, 8'h02, 8'h00, 8'h10, 8'h73, 8'h90, 8'h52, 8'h00, 8'h30};
        for (int i = 0; i < 11; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle();
            send(fr[i]);
        end
    endtask

    task automatic check_good_writes(input string tag);
        check({tag, "_nwr"}, 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            check({tag, "_wr0"}, 64'(wq[0]), {16'd0, 16'h0000, 32'h10000293});
            check({tag, "_wr1"}, 64'(wq[1]), {16'd0, 16'h0004, 32'h00529073});
        end
    endtask

    vec_t tv[19];
    logic [7:0] x;
    int bad;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = mk(8'h00, 1, 0, 0, 16'h0, 32'h0,        0, 0, 0, 1);
        tv[1]  = mk(8'hFF, 1, 0, 0, 16'h0, 32'h0,        0, 0, 0, 1);
        tv[2]  = mk(8'h13, 1, 0, 0, 16'h0, 32'h0,        0, 0, 0, 1);
        tv[3]  = mk(8'hA5, 1, 0, 0, 16'h0, 32'h0,        1, 0, 0, 1);
        tv[4]  = mk(8'h02, 1, 0, 0, 16'h0, 32'h0,        1, 0, 0, 1);
        tv[5]  = mk(8'h93, 1, 0, 0, 16'h0, 32'h0,        1, 0, 0, 1);
        tv[6]  = mk(8'h02, 1, 0, 0, 16'h0, 32'h0,        1, 0, 0, 1);
        tv[7]  = mk(8'h00, 1, 0, 0, 16'h0, 32'h0,        1, 0, 0, 1);
        tv[8]  = mk(8'h10, 1, 0, 1, 16'h0, 32'h10000293, 1, 0, 0, 1);
        tv[9]  = mk(8'hAA, 0, 0, 0, 16'h0, 32'h10000293, 1, 0, 0, 1);
        tv[10] = mk(8'h73, 1, 1, 0, 16'h0, 32'h10000293, 1, 0, 0, 1);
        tv[11] = mk(8'h90, 1, 0, 0, 16'h0, 32'h10000293, 1, 0, 0, 1);
        tv[12] = mk(8'h52, 1, 0, 0, 16'h0, 32'h10000293, 1, 0, 0, 1);
        tv[13] = mk(8'h00, 1, 0, 1, 16'h4, 32'h00529073, 1, 0, 0, 1);
        tv[14] = mk(8'h30, 1, 0, 0, 16'h4, 32'h00529073, 0, 1, 0, 0);
        tv[15] = mk(8'h00, 0, 0, 0, 16'h4, 32'h00529073, 0, 1, 0, 0);
        tv[16] = mk(8'hA5, 1, 0, 0, 16'h4, 32'h00529073, 0, 1, 0, 0);
        tv[17] = mk(8'h00, 0, 1, 0, 16'h4, 32'h00529073, 0, 0, 0, 1);
        tv[18] = mk(8'h00, 0, 0, 0, 16'h4, 32'h00529073, 0, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {im_we, im_addr, im_wdata, cpu_hold, done, err, rx_ready},
              {1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;

        // Noise preamble, good frame with one valid gap, DONE backpressure and clr.
        for (int i = 0; i < 19; i++) begin
            cyc(tv[i].d, tv[i].v, tv[i].c);
            check($sformatf("vec%0d", i),
                  {im_we, im_addr, im_wdata, cpu_hold, done, err, rx_ready},
                  {tv[i].we, tv[i].addr, tv[i].wd, tv[i].hold, tv[i].dn, tv[i].er, tv[i].rdy});
        end

        // Bad checksum: writes still happen, CPU stays held.
        wq.delete();
        send(8'hA5); send(8'h02);
        send(8'h93); send(8'h02); send(8'h00); send(8'h10);
        send(8'h73); send(8'h90); send(8'h52); send(8'h00);
        send(8'h31);
        idle();
        check_good_writes("badchk");
        check("badchk_flags", {err, done, cpu_hold, rx_ready}, {1'b1, 1'b0, 1'b1, 1'b0});
        cyc(8'h00, 1'b0, 1'b1);
        check("badchk_clr", {err, done, cpu_hold, rx_ready}, {1'b0, 1'b0, 1'b0, 1'b1});

        // Bad counts.
        wq.delete();
        send(8'hA5); send(8'h81); idle();
        check("cnt129_flags", {err, done, cpu_hold}, {1'b1, 1'b0, 1'b1});
        pulse_clr();
        send(8'hA5); send(8'h00); idle();
        check("cnt0_flags", {err, done, cpu_hold}, {1'b1, 1'b0, 1'b1});
        pulse_clr();
        check("badcnt_nowr", 64'(wq.size()), 64'd0);
        check("badcnt_idle", {err, cpu_hold, rx_ready}, {1'b0, 1'b0, 1'b1});

        // Random valid gaps.
        wq.delete();
        send_good(1'b1);
        idle();
        check_good_writes("gaps");
        check("gaps_flags", {done, err, cpu_hold, rx_ready}, {1'b1, 1'b0, 1'b0, 1'b0});
        pulse_clr();

        // Reset mid-frame after the fifth data byte.
        send(8'hA5); send(8'h02);
        send(8'h93); send(8'h02); send(8'h00); send(8'h10); send(8'h73);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {im_we, im_addr, im_wdata, cpu_hold, done, err},
              {1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        send_good(1'b0);
        idle();
        check_good_writes("afterrst");
        check("afterrst_done", {done, err}, {1'b1, 1'b0});
        pulse_clr();

        // Full depth: 128 words, word k = k.
        wq.delete();
        x = 8'h00;
        send(8'hA5); send(8'h80);
        for (int k = 0; k < 128; k++) begin
            send(8'(k)); send(8'h00); send(8'h00); send(8'h00);
            x = x ^ 8'(k);
        end
        send(x);
        idle();
        check("full_nwr", 64'(wq.size()), 64'd128);
        bad = 0;
        foreach (wq[k]) if (wq[k] !== {16'(k * 4), 32'(k)}) bad++;
        check("full_contents_bad", 64'(bad), 64'd0);
        if (wq.size() == 128) check("full_last", 64'(wq[127]), {16'd0, 16'h01FC, 32'h0000007F});
        check("full_flags", {done, err, cpu_hold}, {1'b1, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time writer for the instruction memory.
- Receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit words. Each word is written into the instruction memory write port at consecutive word-aligned byte addresses starting at 0.
- Holds the CPU in reset while a load is in progress. Reports done or err at the end of each frame.

Parameters:
- ROM_DEPTH, 128, number of 32-bit words in instruction memory; the frame word count must be 1..ROM_DEPTH.
- ADDR_W, 16, width of im_addr; matches the pc width.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle; a byte is consumed when rx_valid && rx_ready.
- clr  in  1  returns the loader from DONE or ERR to IDLE.
- im_we  out  1  one-cycle write strobe to instruction memory.
- im_addr  out  ADDR_W  byte address of the write, word-aligned (word_index << 2).
- im_wdata  out  32  word to write.
- cpu_hold  out  1  keeps the CPU in reset while loading.
- done  out  1  frame loaded and checksum matched; sticky until clr.
- err  out  1  frame rejected; sticky until clr.

Behaviour:
- Frame format: SYNC_BYTE, then N (word count, 1 byte), then 4*N data bytes (each word LSB first), then CHK.
  - CHK = XOR of all 4*N data bytes.
- Reset (rst_n=0, asynchronous): state=IDLE, im_we=0, im_addr=0, im_wdata=0, cpu_hold=0, done=0, err=0. Byte counter, word counter and checksum accumulator are cleared.
- rx_ready = 1 in IDLE, COUNT, DATA and CHECK; 0 in DONE and ERR.
- States and transitions (all on an accepted byte unless stated):
  - IDLE: byte == SYNC_BYTE -> COUNT, cpu_hold=1. Any other byte is discarded and the state stays IDLE.
  - COUNT: N==0 or N>ROM_DEPTH -> ERR. Otherwise latch N, clear word index, byte index and checksum, then -> DATA.
  - DATA: shift the byte into lane byte_index (0..3) and XOR it into the checksum.
    - On byte_index==3, register the assembled word. The next cycle has im_we=1, im_addr=word_index<<2 and im_wdata=that word.
    - word_index then increments. After word N-1 -> CHECK.
    - im_we is high for exactly one cycle per word. im_addr and im_wdata hold their values after the strobe.
  - CHECK: byte == checksum -> DONE; otherwise -> ERR. The flag asserts the cycle after acceptance.
  - DONE: done=1, cpu_hold=0. On clr -> IDLE with done cleared next cycle.
  - ERR: err=1, cpu_hold=1 (the CPU stays held on a bad image). On clr -> IDLE with err=0 and cpu_hold=0.
- Writes already issued are not rolled back on an error.
- rx_valid may drop at any time. State does not advance without an accepted byte, and there is no timeout.
- clr is ignored outside DONE and ERR.
- A SYNC_BYTE value arriving inside COUNT, DATA or CHECK is treated as data, not as a resync.
- Reset asserted mid-frame aborts immediately and cpu_hold drops. Partially written memory contents are left as they are.
- word_index never wraps: N ≤ ROM_DEPTH is enforced in COUNT.

Decomposition:
- Shared package rv32i_pkg holds:
  - the state enum {IDLE, COUNT, DATA, CHECK, DONE, ERR};
  - SYNC_BYTE;
  - ROM_DEPTH and the ROM word width (32).
- One natural sub-module, im_word_assembler: takes a byte and a strobe, and outputs a little-endian 32-bit word, a word_valid pulse and a running XOR checksum. It has a clear input driven by the COUNT state.
- The instruction memory gains a synchronous write port (we, addr, wdata) driven by this block. Its read path is unchanged.

Test Plan:
- Good load: stream A5 02 93 02 00 10 73 90 52 00 30.
  - Required: im_we pulses with (addr 0x0000, 0x10000293), then (0x0004, 0x00529073).
  - done=1 one cycle after CHK; cpu_hold is 1 during the load and 0 after done.
- Bad checksum: same frame with CHK=0x31.
  - Required: both writes occur, err=1, done=0, cpu_hold stays 1.
  - clr -> IDLE with err=0 and cpu_hold=0.
- Bad count: A5 81 (129 > ROM_DEPTH) -> err=1 with no im_we. A5 00 -> err=1 with no im_we.
- Preamble noise and backpressure: bytes 00 FF 13 before A5 produce no effect. Random rx_valid gaps inside the good frame give identical writes and done=1. rx_ready=0 while in DONE.
- Reset mid-frame: rst_n=0 after the 5th data byte -> all outputs 0 immediately. A fresh good frame then loads correctly from address 0.
- Full depth: N=128 with word k = k -> 128 writes, last at im_addr 0x01FC with data 0x0000007F; done=1 with the correct XOR checksum.
